tx_burst_arbiter: RTL and testbench

- Shares one 32-bit valid/ready transmit channel among NUM_REQ burst sources, such as tx-style generators that send fixed-length bursts.
- Grants the channel to one requester for one complete burst of BURST_LEN beats, using round-robin order.
- Aborts a burst whose source stalls too long.
- Sits between the burst generators and the single downstream receiver.

---
 rtl/tx_burst_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_tx_burst_arbiter.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_burst_arbiter.sv
// ---------------------------------------------------------------------------
// tx_burst_arbiter
//
// Shares one 32-bit valid/ready transmit channel among NUM_REQ burst sources.
// One requester at a time owns the channel for a complete burst of BURST_LEN
// beats. Ownership rotates round-robin. A burst is abandoned when its owner
// keeps valid low for MAX_GAP consecutive cycles.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_data      requester data, requester i in bits [32*i+31:32*i]
//   in_valid     per-requester valid
//   in_ready     per-requester ready (only the granted requester is ever acked)
//   out_data     shared channel data
//   out_valid    shared channel valid
//   out_ready    downstream ready
//   grant        one-hot grant, all zero while idle
//   busy         high while a burst is in progress
//   burst_done   one-cycle pulse after a full burst completes
//   burst_abort  one-cycle pulse after a burst is abandoned on timeout
// ---------------------------------------------------------------------------
module tx_burst_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int BURST_LEN = 8,
   parameter int MAX_GAP   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [32*NUM_REQ-1:0]  in_data,
   input  logic [NUM_REQ-1:0]     in_valid,
   output logic [NUM_REQ-1:0]     in_ready,
   output logic [31:0]            out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   busy,
   output logic                   burst_done,
   output logic                   burst_abort
);

   localparam int IDXW  = $clog2(NUM_REQ);
   localparam int BEATW = $clog2(BURST_LEN) + 1;

   localparam logic [IDXW-1:0]  LAST_REQ  = IDXW'(NUM_REQ - 1);
   localparam logic [BEATW-1:0] LAST_BEAT = BEATW'(BURST_LEN - 1);
   localparam logic [7:0]       GAP_LIMIT = 8'(MAX_GAP - 1);

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   state_t             state_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [IDXW-1:0]    grantIdx_q;
   logic [IDXW-1:0]    lastGrant_q;
   logic [BEATW-1:0]   beatCnt_q;
   logic [7:0]         gapCnt_q;
   logic               busy_q;
   logic               burstDone_q;
   logic               burstAbort_q;

   logic [31:0]        reqData [NUM_REQ];
   logic               grantValid;
   logic               anyValid;
   logic               hiFound;
   logic [IDXW-1:0]    hiIdx;
   logic [IDXW-1:0]    loIdx;
   logic [IDXW-1:0]    pickIdx_d;

   // Unpack the flat data bus into one word per requester so the mux below
   // can be indexed directly by the registered grant index.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         reqData[i] = in_data[32*i +: 32];
      end
   end

   // Round-robin pick: the lowest valid requester above the last winner,
   // otherwise wrap around to the lowest valid requester overall. Scanning
   // downwards lets the final write in each category be the lowest index.
   always_comb begin
      hiFound = 1'b0;
      hiIdx   = '0;
      loIdx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            loIdx = IDXW'(i);
            if (i > int'(lastGrant_q)) begin
               hiFound = 1'b1;
               hiIdx   = IDXW'(i);
            end
         end
      end
      pickIdx_d = hiFound ? hiIdx : loIdx;
   end

   assign anyValid   = |in_valid;
   assign grantValid = in_valid[grantIdx_q];

   // Control FSM. Every control output is a register so that grant, busy and
   // the two pulses change only on clock edges. The status pulses default low
   // each cycle and are raised only on the edge that leaves BURST, which also
   // guarantees at least one IDLE cycle between consecutive bursts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         grantIdx_q   <= '0;
         lastGrant_q  <= LAST_REQ;
         beatCnt_q    <= '0;
         gapCnt_q     <= '0;
         busy_q       <= 1'b0;
         burstDone_q  <= 1'b0;
         burstAbort_q <= 1'b0;
      end else begin
         burstDone_q  <= 1'b0;
         burstAbort_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (anyValid) begin
                  state_q    <= BURST;
                  grant_q    <= NUM_REQ'(1) << pickIdx_d;
                  grantIdx_q <= pickIdx_d;
                  busy_q     <= 1'b1;
                  beatCnt_q  <= '0;
                  gapCnt_q   <= '0;
               end
            end
            BURST: begin
               if (grantValid) begin
                  // Any cycle with valid high restarts the silence window,
                  // including cycles stalled by downstream backpressure.
                  gapCnt_q <= '0;
                  if (out_ready) begin
                     if (beatCnt_q == LAST_BEAT) begin
                        state_q     <= IDLE;
                        grant_q     <= '0;
                        busy_q      <= 1'b0;
                        lastGrant_q <= grantIdx_q;
                        beatCnt_q   <= '0;
                        burstDone_q <= 1'b1;
                     end else begin
                        beatCnt_q <= beatCnt_q + BEATW'(1);
                     end
                  end
               end else begin
                  if (gapCnt_q == GAP_LIMIT) begin
                     state_q      <= IDLE;
                     grant_q      <= '0;
                     busy_q       <= 1'b0;
                     lastGrant_q  <= grantIdx_q;
                     beatCnt_q    <= '0;
                     gapCnt_q     <= '0;
                     burstAbort_q <= 1'b1;
                  end else begin
                     gapCnt_q <= gapCnt_q + 8'd1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Datapath steering follows the registered grant. While idle the grant
   // is zero, which forces every ready low and blanks the shared channel.
   assign out_valid   = busy_q & grantValid;
   assign out_data    = busy_q ? reqData[grantIdx_q] : 32'd0;
   assign in_ready    = out_ready ? grant_q : '0;

   assign grant       = grant_q;
   assign busy        = busy_q;
   assign burst_done  = burstDone_q;
   assign burst_abort = burstAbort_q;

endmodule

// File: tb/tb_tx_burst_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tx_burst_arbiter
//
// Bench for tx_burst_arbiter with four requesters, 8-beat bursts and a
// 16-cycle silence limit. Each requester is a simple source that presents
// {requester index, sequence number} and advances on every accepted beat.
// Scenario tasks push the beats they expect onto a scoreboard in the order
// the arbiter should deliver them; a negedge monitor pops one entry per
// downstream handshake and also checks the ready/grant relationship.
// ---------------------------------------------------------------------------
module tb_tx_burst_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int BURST_LEN = 8;
   localparam int MAX_GAP   = 16;

   logic                  clk;
   logic                  rst;
   logic [32*NUM_REQ-1:0] in_data;
   logic [NUM_REQ-1:0]    in_valid;
   logic [NUM_REQ-1:0]    in_ready;
   logic [31:0]           out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [NUM_REQ-1:0]    grant;
   logic                  busy;
   logic                  burst_done;
   logic                  burst_abort;

   typedef struct {
      int          req;
      logic [31:0] data;
   } beat_t;

   beat_t sbQ[$];

   int assertCount = 0;
   int failCount   = 0;
   int doneCount   = 0;
   int abortCount  = 0;

   int srcLeft [NUM_REQ];
   int srcSeq  [NUM_REQ];

   beat_t              monExp;
   logic [NUM_REQ-1:0] monGrant;
   logic [NUM_REQ-1:0] monReady;

   tx_burst_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .BURST_LEN (BURST_LEN),
      .MAX_GAP   (MAX_GAP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .grant       (grant),
      .busy        (busy),
      .burst_done  (burst_done),
      .burst_abort (burst_abort)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a scenario wedges despite its own cycle bounds.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] beatData(input int req, input int seq);
      return {8'(req), 24'(seq)};
   endfunction

   task automatic driveSources();
      for (int i = 0; i < NUM_REQ; i++) begin
         in_valid[i]          = (srcLeft[i] > 0);
         in_data[32*i +: 32]  = beatData(i, srcSeq[i]);
      end
   endtask

   task automatic startSource(input int req, input int beats);
      srcLeft[req] = beats;
      srcSeq[req]  = 1;
      driveSources();
   endtask

   task automatic pushBurst(input int req, input int firstSeq, input int n);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.req  = req;
         b.data = beatData(req, firstSeq + k);
         sbQ.push_back(b);
      end
   endtask

   // Advance one clock. Source-side handshakes are captured at the negedge
   // (inputs and ready are stable there), sources advance just after the
   // posedge, and the task returns 2 units after the edge so callers can
   // check settled outputs and drive new inputs well before the next negedge.
   task automatic stepCycle();
      logic [NUM_REQ-1:0] hs;
      @(negedge clk);
      hs = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (hs[i]) begin
            srcSeq[i]  = srcSeq[i] + 1;
            srcLeft[i] = srcLeft[i] - 1;
         end
      end
      driveSources();
      #1;
   endtask

   function automatic bit sourcesIdle();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (srcLeft[i] != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic runUntilDrained(input int maxCycles, input string tag);
      int n;
      n = 0;
      while (!(sbQ.size() == 0 && busy === 1'b0 && sourcesIdle()) && n < maxCycles) begin
         stepCycle();
         n++;
      end
      assertCount++;
      if (n >= maxCycles) begin
         failCount++;
         $display("[TB] FAIL %s_drain: %0d beats still pending after %0d cycles, expected 0", tag, sbQ.size(), n);
      end
      stepCycle();
   endtask

   task automatic doReset();
      rst       = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         srcLeft[i] = 0;
         srcSeq[i]  = 1;
      end
      driveSources();
      stepCycle();
      rst = 1'b0;
   endtask

   // Downstream monitor: scoreboard compare on every handshake plus the
   // structural relations between grant, ready and the status pulses.
   always @(negedge clk) begin
      if (!rst) begin
         monReady = out_ready ? grant : '0;
         assertCount++;
         if (in_ready !== monReady) begin
            failCount++;
            $display("[TB] FAIL in_ready_vs_grant: in_ready=%b required %b (grant=%b)", in_ready, monReady, grant);
         end
         assertCount++;
         if (!$onehot0(grant)) begin
            failCount++;
            $display("[TB] FAIL grant_onehot: grant=%b required one-hot or zero", grant);
         end
         assertCount++;
         if (burst_done === 1'b1 && burst_abort === 1'b1) begin
            failCount++;
            $display("[TB] FAIL done_abort_exclusive: done=%b abort=%b required not both", burst_done, burst_abort);
         end
         if (burst_done === 1'b1 || burst_abort === 1'b1) begin
            assertCount++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
               failCount++;
               $display("[TB] FAIL gap_cycle: out_valid=%b busy=%b required 0 0", out_valid, busy);
            end
         end
         if (burst_done === 1'b1) doneCount++;
         if (burst_abort === 1'b1) abortCount++;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            assertCount++;
            if (sbQ.size() == 0) begin
               failCount++;
               $display("[TB] FAIL sb_unexpected: beat data=%h grant=%b, expected none", out_data, grant);
            end else begin
               monExp   = sbQ.pop_front();
               monGrant = '0;
               monGrant[monExp.req] = 1'b1;
               if (out_data !== monExp.data || grant !== monGrant) begin
                  failCount++;
                  $display("[TB] FAIL sb_beat: data=%h grant=%b required data=%h grant=%b", out_data, grant, monExp.data, monGrant);
               end
            end
         end
      end
   end

   task automatic test_reset();
      assertCount++;
      if (grant !== 4'b0000) begin failCount++; $display("[TB] FAIL reset_grant: %b required 0000", grant); end
      assertCount++;
      if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: %b required 0", busy); end
      assertCount++;
      if (burst_done !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done: %b required 0", burst_done); end
      assertCount++;
      if (burst_abort !== 1'b0) begin failCount++; $display("[TB] FAIL reset_abort: %b required 0", burst_abort); end
      assertCount++;
      if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_valid: %b required 0", out_valid); end
      assertCount++;
      if (out_data !== 32'd0) begin failCount++; $display("[TB] FAIL reset_out_data: %h required 0", out_data); end
      assertCount++;
      if (in_ready !== 4'b0000) begin failCount++; $display("[TB] FAIL reset_in_ready: %b required 0000", in_ready); end
   endtask

   // Requester 0 alone: grant one cycle after valid, eight beats carrying
   // 1..8, done pulse in the idle cycle that follows the last beat.
   task automatic test_single_burst();
      startSource(0, BURST_LEN);
      pushBurst(0, 1, BURST_LEN);
      stepCycle();
      assertCount++;
      if (grant !== 4'b0001 || busy !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL single_grant_latency: grant=%b busy=%b required 0001 1", grant, busy);
      end
      assertCount++;
      if (out_valid !== 1'b1 || out_data !== 32'd1) begin
         failCount++;
         $display("[TB] FAIL single_first_beat: valid=%b data=%h required 1 00000001", out_valid, out_data);
      end
      repeat (BURST_LEN) stepCycle();
      assertCount++;
      if (burst_done !== 1'b1 || grant !== 4'b0000 || out_valid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL single_done: done=%b grant=%b valid=%b required 1 0000 0", burst_done, grant, out_valid);
      end
      stepCycle();
      assertCount++;
      if (burst_done !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL single_done_width: done=%b required 0", burst_done);
      end
      assertCount++;
      if (sbQ.size() != 0) begin
         failCount++;
         $display("[TB] FAIL single_beats: %0d beats missing, required 0", sbQ.size());
      end
   endtask

   // Requesters 0 and 2 always valid: bursts alternate 0, 2, 0, 2.
   task automatic test_round_robin();
      int d0;
      doReset();
      d0 = doneCount;
      startSource(0, 2 * BURST_LEN);
      startSource(2, 2 * BURST_LEN);
      pushBurst(0, 1, BURST_LEN);
      pushBurst(2, 1, BURST_LEN);
      pushBurst(0, BURST_LEN + 1, BURST_LEN);
      pushBurst(2, BURST_LEN + 1, BURST_LEN);
      runUntilDrained(80, "rr");
      assertCount++;
      if (doneCount - d0 != 4) begin
         failCount++;
         $display("[TB] FAIL rr_done_count: %0d bursts completed, required 4", doneCount - d0);
      end
   endtask

   // Requester 1 with out_ready alternating 1,0,1,...: beats land on every
   // other burst cycle, so the burst occupies 2*BURST_LEN-1 busy cycles
   // (one more counting the arbitration cycle) and must not time out.
   task automatic test_backpressure();
      int k;
      int a0;
      a0 = abortCount;
      startSource(1, BURST_LEN);
      pushBurst(1, 1, BURST_LEN);
      stepCycle();
      assertCount++;
      if (grant !== 4'b0010) begin
         failCount++;
         $display("[TB] FAIL bp_grant: grant=%b required 0010", grant);
      end
      k = 0;
      while (busy === 1'b1 && k < 40) begin
         out_ready = (k % 2 == 0);
         stepCycle();
         k++;
      end
      out_ready = 1'b1;
      assertCount++;
      if (k != 2 * BURST_LEN - 1 || burst_done !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL bp_duration: %0d busy cycles done=%b, required %0d 1", k, burst_done, 2 * BURST_LEN - 1);
      end
      runUntilDrained(20, "bp");
      assertCount++;
      if (abortCount != a0) begin
         failCount++;
         $display("[TB] FAIL bp_no_abort: %0d aborts, required 0", abortCount - a0);
      end
   endtask

   // Downstream stall longer than the silence limit while valid stays high
   // must not abort the burst.
   task automatic test_stall_no_abort();
      int a0;
      a0 = abortCount;
      startSource(1, BURST_LEN);
      pushBurst(1, 1, BURST_LEN);
      stepCycle();
      stepCycle();
      out_ready = 1'b0;
      repeat (MAX_GAP + 4) stepCycle();
      assertCount++;
      if (busy !== 1'b1 || grant !== 4'b0010) begin
         failCount++;
         $display("[TB] FAIL stall_still_busy: busy=%b grant=%b required 1 0010", busy, grant);
      end
      out_ready = 1'b1;
      runUntilDrained(30, "stall");
      assertCount++;
      if (abortCount != a0) begin
         failCount++;
         $display("[TB] FAIL stall_no_abort: %0d aborts, required 0", abortCount - a0);
      end
   endtask

   // Requester 3 sends 3 beats then goes silent. The abort must follow the
   // MAX_GAP-th silent cycle, and requester 0 (waiting) wins next.
   task automatic test_timeout();
      int k;
      int lowCycles;
      startSource(3, 3);
      startSource(0, BURST_LEN);
      pushBurst(3, 1, 3);
      pushBurst(0, 1, BURST_LEN);
      stepCycle();
      assertCount++;
      if (grant !== 4'b1000) begin
         failCount++;
         $display("[TB] FAIL to_grant: grant=%b required 1000", grant);
      end
      k = 0;
      lowCycles = 0;
      while (burst_abort !== 1'b1 && k < 40) begin
         if (busy === 1'b1 && in_valid[3] === 1'b0) lowCycles++;
         stepCycle();
         k++;
      end
      assertCount++;
      if (lowCycles != MAX_GAP || burst_abort !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL to_gap_length: %0d silent cycles abort=%b, required %0d 1", lowCycles, burst_abort, MAX_GAP);
      end
      assertCount++;
      if (grant !== 4'b0000 || burst_done !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL to_abort_state: grant=%b done=%b required 0000 0", grant, burst_done);
      end
      stepCycle();
      assertCount++;
      if (burst_abort !== 1'b0 || grant !== 4'b0001) begin
         failCount++;
         $display("[TB] FAIL to_next_grant: abort=%b grant=%b required 0 0001", burst_abort, grant);
      end
      runUntilDrained(30, "to");
   endtask

   // Reset lands after the fifth beat of a requester 2 burst: outputs clear
   // in the same cycle and the first grant afterwards goes to requester 0.
   task automatic test_reset_midburst();
      int k;
      startSource(2, BURST_LEN);
      startSource(0, BURST_LEN);
      pushBurst(2, 1, 5);
      stepCycle();
      assertCount++;
      if (grant !== 4'b0100) begin
         failCount++;
         $display("[TB] FAIL rstmid_grant: grant=%b required 0100", grant);
      end
      k = 0;
      while (srcSeq[2] < 6 && k < 20) begin
         stepCycle();
         k++;
      end
      rst = 1'b1;
      #1;
      assertCount++;
      if (out_valid !== 1'b0 || grant !== 4'b0000 || in_ready !== 4'b0000 || busy !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL rstmid_async: valid=%b grant=%b ready=%b busy=%b required 0 0000 0000 0", out_valid, grant, in_ready, busy);
      end
      assertCount++;
      if (sbQ.size() != 0) begin
         failCount++;
         $display("[TB] FAIL rstmid_partial: %0d beats missing before reset, required 0", sbQ.size());
      end
      stepCycle();
      rst = 1'b0;
      pushBurst(0, 1, BURST_LEN);
      stepCycle();
      assertCount++;
      if (grant !== 4'b0001) begin
         failCount++;
         $display("[TB] FAIL rstmid_first_grant: grant=%b required 0001", grant);
      end
      srcLeft[2] = 0;
      driveSources();
      runUntilDrained(30, "rstmid");
   endtask

   // Requester 1 keeps valid after its burst; requester 3 rises on the final
   // beat. Requester 3 must be served before requester 1 again.
   task automatic test_back_to_back();
      int k;
      startSource(1, 2 * BURST_LEN);
      pushBurst(1, 1, BURST_LEN);
      pushBurst(3, 1, BURST_LEN);
      pushBurst(1, BURST_LEN + 1, BURST_LEN);
      stepCycle();
      assertCount++;
      if (grant !== 4'b0010) begin
         failCount++;
         $display("[TB] FAIL b2b_grant: grant=%b required 0010", grant);
      end
      k = 0;
      while (srcSeq[1] < BURST_LEN && k < 20) begin
         stepCycle();
         k++;
      end
      startSource(3, BURST_LEN);
      stepCycle();
      assertCount++;
      if (burst_done !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL b2b_done: done=%b required 1", burst_done);
      end
      stepCycle();
      assertCount++;
      if (grant !== 4'b1000) begin
         failCount++;
         $display("[TB] FAIL b2b_fair_grant: grant=%b required 1000", grant);
      end
      runUntilDrained(60, "b2b");
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         srcLeft[i] = 0;
         srcSeq[i]  = 1;
      end
      driveSources();
      stepCycle();
      stepCycle();
      test_reset();
      rst = 1'b0;
      stepCycle();

      $display("[TB] single burst");
      test_single_burst();
      $display("[TB] round robin");
      test_round_robin();
      $display("[TB] backpressure");
      test_backpressure();
      $display("[TB] long stall");
      test_stall_no_abort();
      $display("[TB] timeout");
      test_timeout();
      $display("[TB] reset mid-burst");
      test_reset_midburst();
      $display("[TB] back to back");
      test_back_to_back();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
